// File: rtl/sm_fetch_pkg.sv
// rtl/sm_fetch_pkg.sv - shared types and constants for the fetch stage
package sm_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/sm_fetch_if.sv
// rtl/sm_fetch_if.sv - memory, downstream and redirect signals of the fetch stage
interface sm_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/sm_register_sync_we.sv
// rtl/sm_register_sync_we.sv - write-enabled register with synchronous active-low reset
module sm_register_sync_we #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_o <= RESET_VALUE;
    end else if (we_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/sm_fetch.sv
// rtl/sm_fetch.sv - instruction fetch: owns the PC, one outstanding imem request, redirect flush
module sm_fetch
  import sm_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  sm_fetch_if.master  bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, tgt_q, instr_pc_q, redir_pc;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  pc_we, tgt_we, instr_we, imem_req;

  assign redir_pc = bus.redirect_pc & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.redirect) begin
          state_d = bus.imem_ack ? ST_FETCH : ST_DROP;
        end else if (bus.imem_ack) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD:  if (bus.redirect || bus.instr_ready) state_d = ST_FETCH;
      ST_DROP:  if (bus.imem_ack) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A redirect without ack must keep the old request alive, so its target parks in tgt_q.
  always_comb begin
    imem_req = 1'b0;
    pc_we    = 1'b0;
    pc_d     = pc_q + ADDR_WIDTH'(PC_STEP);
    tgt_we   = 1'b0;
    instr_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.redirect) begin
          pc_we = 1'b1;
          pc_d  = redir_pc;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.redirect) begin
          if (bus.imem_ack) begin
            pc_we = 1'b1;
            pc_d  = redir_pc;
          end else begin
            tgt_we = 1'b1;
          end
        end else if (bus.imem_ack) begin
          pc_we    = 1'b1;
          instr_we = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.redirect) begin
          pc_we = 1'b1;
          pc_d  = redir_pc;
        end
      end
      ST_DROP: begin
        imem_req = 1'b1;
        if (bus.redirect) begin
          if (bus.imem_ack) begin
            pc_we = 1'b1;
            pc_d  = redir_pc;
          end else begin
            tgt_we = 1'b1;
          end
        end else if (bus.imem_ack) begin
          pc_we = 1'b1;
          pc_d  = tgt_q;
        end
      end
      default: ;
    endcase
  end

  sm_register_sync_we #(.WIDTH(ADDR_WIDTH), .RESET_VALUE(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .we_i(pc_we), .d_i(pc_d), .q_o(pc_q)
  );

  sm_register_sync_we #(.WIDTH(ADDR_WIDTH), .RESET_VALUE('0)) u_tgt (
    .clk(clk), .rst_n(rst_n), .we_i(tgt_we), .d_i(redir_pc), .q_o(tgt_q)
  );

  sm_register_sync_we #(.WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_instr (
    .clk(clk), .rst_n(rst_n), .we_i(instr_we), .d_i(bus.imem_rdata), .q_o(instr_q)
  );

  sm_register_sync_we #(.WIDTH(ADDR_WIDTH), .RESET_VALUE('0)) u_instr_pc (
    .clk(clk), .rst_n(rst_n), .we_i(instr_we), .d_i(pc_q), .q_o(instr_pc_q)
  );

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule
